uc_multiciclo: RTL
==================

Name: uc_multiciclo

Overview:
- Parametrised multicycle control unit; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC and inserts wait states on slow instruction memory.
- Adds JNZ, CALL, RET and HALT, and manages a return-address stack pointer.
- Drives the datapath strobes: PC load/select, register-file write, flag write, ALU op, stack push/pop.

Parameters:
- OPCODE_W, 6, opcode width; major fields are opcode[OPCODE_W-1:OPCODE_W-6].
- ALU_OP_W, 3, width of op_alu.
- STACK_DEPTH, 8, return-stack entries; sp is $clog2(STACK_DEPTH+1) bits wide.
- WAIT_MAX, 15, maximum consecutive mem_ready-low cycles in FETCH before error.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  instruction opcode from instruction memory, valid when mem_ready=1
- z  in  1  zero flag from flag register
- mem_ready  in  1  instruction memory data valid
- mem_re  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- pc_we  out  1  load PC
- s_inc  out  1  PC source: 1 = PC+1, 0 = jump target
- s_ret  out  1  PC source override: 1 = stack top (RET)
- s_inm  out  1  register-file write source: 1 = immediate
- we3  out  1  register-file write enable
- wez  out  1  zero-flag write enable
- op_alu  out  ALU_OP_W  ALU operation
- push  out  1  write PC+1 to stack[sp], then increment sp
- pop  out  1  decrement sp
- sp  out  $clog2(STACK_DEPTH+1)  stack pointer (count of entries)
- halted  out  1  HALT executed
- err  out  1  fetch timeout, stack overflow or stack underflow

Behaviour:
- All outputs are combinational from state plus latched opcode (op_q) and z; op_q, sp, wait counter and state are registered.
- Reset (any state, any cycle) forces next edge to: state=FETCH, op_q=0, sp=0, wait counter=0, halted=0, err=0.
- After reset, the FETCH-state defaults below apply immediately; every other strobe is 0. Reset mid-instruction aborts it with no strobes.
- FETCH:
  - mem_re=1.
  - mem_ready=0: increment wait counter. Reaching WAIT_MAX+1 consecutive low cycles goes to ERROR.
  - mem_ready=1: ir_we=1, op_q<=opcode, wait counter<=0, go to DECODE.
- DECODE: one cycle, no strobes; go to EXEC (HALT goes to HALT; stack violations go to ERROR, see below).
- EXEC: one cycle of strobes, then FETCH. Minimum latency is 3 cycles per instruction. Decode of op_q (6 MSBs):
  - 0000??  load immediate: we3=1, s_inm=1, pc_we=1, s_inc=1.
  - 1ooo??  ALU: we3=1, wez=1, op_alu=ooo (zero-extended to ALU_OP_W), pc_we=1, s_inc=1.
  - 001000  jump: pc_we=1, s_inc=0.
  - 001001  JZ: pc_we=1, s_inc = z (sequential when z=1, matching the existing encoding).
  - 001010  JNZ: pc_we=1, s_inc = ~z.
  - 001011  CALL: push=1, pc_we=1, s_inc=0, sp<=sp+1.
  - 001100  RET: pop=1, pc_we=1, s_ret=1, sp<=sp-1.
  - 001111  HALT: handled in DECODE; goes to HALT.
  - others  NOP: pc_we=1, s_inc=1.
  - z is sampled combinationally in EXEC.
- Stack violations:
  - CALL with sp==STACK_DEPTH or RET with sp==0 goes DECODE to ERROR; no push/pop, sp unchanged.
- HALT: halted=1, all strobes 0, stays until reset.
- ERROR: err=1, all strobes 0, stays until reset.
- Exactly one of {push, pop} at most per cycle; s_ret=1 only with pc_we=1.

Test Plan:
- Reset, then opcode=100100 (A negated) with mem_ready=1 -> cycle 0 ir_we=1; cycle 2 we3=1, wez=1, op_alu=001, pc_we=1, s_inc=1; cycle 3 back in FETCH.
- JZ (001001) with z=0, then JNZ (001010) with z=0 -> JZ EXEC s_inc=0; JNZ EXEC s_inc=1; both pc_we=1.
- mem_ready held low 5 cycles then high, WAIT_MAX=15 -> mem_re high 6 cycles, ir_we only in 6th, no err. Held low 16 cycles -> err=1 and sticky.
- STACK_DEPTH=2: three CALLs -> sp 1, 2, then err=1 with no third push. Separately, RET at sp=0 -> err=1, pop never asserted.
- CALL, CALL, RET, RET -> sp 1, 2, 1, 0; RET EXEC shows s_ret=1, pc_we=1, pop=1.
- HALT (001111) -> halted=1 from cycle 2 onward, no strobes. Reset asserted mid-EXEC of an ALU op -> no we3 that cycle, next cycle FETCH, halted=0, sp=0.

Source files
------------

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC sequencing with fetch wait
// states, JZ/JNZ/CALL/RET/HALT and a return-stack pointer.
// Ports: clk, reset (sync, active-high), opcode, z, mem_ready in;
//        datapath strobes (mem_re, ir_we, pc_we, s_inc, s_ret, s_inm,
//        we3, wez, op_alu, push, pop), sp, halted, err out.
module uc_multiciclo #(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 3,
    parameter int STACK_DEPTH = 8,
    parameter int WAIT_MAX    = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [OPCODE_W-1:0]                opcode,
    input  logic                               z,
    input  logic                               mem_ready,
    output logic                               mem_re,
    output logic                               ir_we,
    output logic                               pc_we,
    output logic                               s_inc,
    output logic                               s_ret,
    output logic                               s_inm,
    output logic                               we3,
    output logic                               wez,
    output logic [ALU_OP_W-1:0]                op_alu,
    output logic                               push,
    output logic                               pop,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               halted,
    output logic                               err
);

    localparam int SW = $clog2(STACK_DEPTH + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [SW-1:0]       sp_q, sp_d;
    logic [WW-1:0]       wait_q, wait_d;

    logic [5:0] maj;
    logic       is_call;
    logic       is_ret;
    logic       is_halt;

    assign maj     = op_q[OPCODE_W-1 -: 6];
    assign is_call = (maj == 6'b001011);
    assign is_ret  = (maj == 6'b001100);
    assign is_halt = (maj == 6'b001111);
    assign sp      = sp_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sp_d    = sp_q;
        wait_d  = wait_q;
        mem_re  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        s_inc   = 1'b0;
        s_ret   = 1'b0;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        op_alu  = '0;
        push    = 1'b0;
        pop     = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;

        // Reset suppresses every strobe in the cycle it is asserted,
        // so an instruction caught in EXEC has no side effects.
        if (reset) begin
            state_d = S_FETCH;
            op_d    = '0;
            sp_d    = '0;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        op_d    = opcode;
                        wait_d  = '0;
                        state_d = S_DECODE;
                    end else if (wait_q == WW'(WAIT_MAX)) begin
                        // This is low cycle WAIT_MAX+1: give up.
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    // Stack checks here keep push/pop off in EXEC.
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else if ((is_call && sp_q == SW'(STACK_DEPTH)) ||
                                 (is_ret && sp_q == '0)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    pc_we   = 1'b1;
                    unique casez (maj)
                        6'b1?????: begin
                            we3    = 1'b1;
                            wez    = 1'b1;
                            op_alu = ALU_OP_W'(maj[4:2]);
                            s_inc  = 1'b1;
                        end
                        6'b0000??: begin
                            we3   = 1'b1;
                            s_inm = 1'b1;
                            s_inc = 1'b1;
                        end
                        6'b001000: s_inc = 1'b0;
                        // JZ falls through (PC+1) when z is set.
                        6'b001001: s_inc = z;
                        6'b001010: s_inc = ~z;
                        6'b001011: begin
                            push = 1'b1;
                            sp_d = sp_q + 1'b1;
                        end
                        6'b001100: begin
                            pop   = 1'b1;
                            s_ret = 1'b1;
                            sp_d  = sp_q - 1'b1;
                        end
                        default: s_inc = 1'b1;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                S_ERROR: err    = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        op_q    <= op_d;
        sp_q    <= sp_d;
        wait_q  <= wait_d;
    end

endmodule
